// File: rtl/pc_unit.sv
// Program-counter unit at the front of IF.
// Next-PC select with stall-held redirect, misalign trap and halt FSM.
module pc_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h8),
  parameter int               INC       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc_in,
  input  logic             exc_req,
  input  logic             halt_req,
  input  logic             resume,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             redirect_pending,
  output logic             halted,
  output logic             misalign,
  output logic [WIDTH-1:0] bad_addr
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pv_q, pv_d;
  logic             mis_q, mis_d;
  logic [WIDTH-1:0] bad_q, bad_d;

  logic             rd_vld;
  logic [WIDTH-1:0] rd_tgt;
  logic             ap_vld;
  logic [WIDTH-1:0] ap_tgt;
  logic [WIDTH-1:0] seq_pc;

  assign seq_pc = pc_q + WIDTH'(INC);

  // Highest-priority new redirect this cycle: eret, then jump, then branch.
  always_comb begin
    rd_tgt = '0;
    unique case (1'b1)
      eret:                          rd_tgt = epc_in;
      !eret && jump:                 rd_tgt = jump_target;
      !eret && !jump && branch_taken: rd_tgt = branch_target;
      default:                       rd_tgt = '0;
    endcase
  end

  assign rd_vld = eret | jump | branch_taken;

  // Target applied on an unstalled cycle: a new redirect beats the pending one.
  assign ap_vld = rd_vld | pv_q;
  assign ap_tgt = rd_vld ? rd_tgt : pend_q;

  // Next-state and next-PC selection for the RUN/HALT machine.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    pv_d    = pv_q;
    mis_d   = 1'b0;
    bad_d   = bad_q;
    case (state_q)
      S_RUN: begin
        if (exc_req) begin
          pc_d = EXC_VEC;
          pv_d = 1'b0;
        end else if (stall) begin
          if (rd_vld) begin
            pend_d = rd_tgt;
            pv_d   = 1'b1;
          end
        end else begin
          pv_d = 1'b0;
          if (ap_vld) begin
            if (ap_tgt[1:0] != 2'b00) begin
              pc_d  = EXC_VEC;
              mis_d = 1'b1;
              bad_d = ap_tgt;
            end else begin
              pc_d = ap_tgt;
            end
          end else begin
            pc_d = seq_pc;
          end
          if (halt_req) state_d = S_HALT;
        end
      end
      S_HALT: begin
        if (exc_req) begin
          pc_d    = EXC_VEC;
          pv_d    = 1'b0;
          state_d = S_RUN;
        end else if (resume) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      pc_q    <= RESET_VEC;
      pend_q  <= '0;
      pv_q    <= 1'b0;
      mis_q   <= 1'b0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      pv_q    <= pv_d;
      mis_q   <= mis_d;
      bad_q   <= bad_d;
    end
  end

  assign pc_out           = pc_q;
  assign pc_plus4         = seq_pc;
  assign redirect_pending = pv_q;
  assign halted           = (state_q == S_HALT);
  assign misalign         = mis_q;
  assign bad_addr         = bad_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus random traffic
// checked cycle by cycle against a behavioural model.
module tb_pc_unit;

  localparam logic [31:0] EXC = 32'h8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 0, branch_taken = 0, jump = 0, eret = 0;
  logic        exc_req = 0, halt_req = 0, resume = 0;
  logic [31:0] branch_target = 0, jump_target = 0, epc_in = 0;

  logic [31:0] pc_out, pc_plus4, bad_addr;
  logic        redirect_pending, halted, misalign;

  logic [7:0]  pc8, pc8_p4, bad8;
  logic        pend8, halt8, mis8;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  logic [31:0] m_pc, m_pend, m_bad;
  logic        m_pv, m_halt, m_mis;

  always #5 clk = ~clk;

  pc_unit u_dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .eret(eret), .epc_in(epc_in), .exc_req(exc_req),
    .halt_req(halt_req), .resume(resume),
    .pc_out(pc_out), .pc_plus4(pc_plus4),
    .redirect_pending(redirect_pending), .halted(halted),
    .misalign(misalign), .bad_addr(bad_addr)
  );

  pc_unit #(
    .WIDTH(8), .RESET_VEC(8'h00), .EXC_VEC(8'h08), .INC(4)
  ) u_dut8 (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target[7:0]),
    .jump(jump), .jump_target(jump_target[7:0]),
    .eret(eret), .epc_in(epc_in[7:0]), .exc_req(exc_req),
    .halt_req(halt_req), .resume(resume),
    .pc_out(pc8), .pc_plus4(pc8_p4),
    .redirect_pending(pend8), .halted(halt8),
    .misalign(mis8), .bad_addr(bad8)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_pc = 0; m_pend = 0; m_bad = 0;
    m_pv = 0; m_halt = 0; m_mis = 0;
  endtask

  // One clock edge of the architectural rules.
  task automatic m_step();
    logic [31:0] t;
    logic        have;
    m_mis = 0;
    if (exc_req) begin
      m_pc = EXC; m_pv = 0; m_halt = 0;
    end else if (m_halt) begin
      if (resume) m_halt = 0;
    end else if (stall) begin
      if (eret)              begin m_pend = epc_in;        m_pv = 1; end
      else if (jump)         begin m_pend = jump_target;   m_pv = 1; end
      else if (branch_taken) begin m_pend = branch_target; m_pv = 1; end
    end else begin
      have = 1;
      if (eret)              t = epc_in;
      else if (jump)         t = jump_target;
      else if (branch_taken) t = branch_target;
      else if (m_pv)         t = m_pend;
      else begin have = 0; t = 0; end
      if (!have)            m_pc = m_pc + 4;
      else if (t % 4 != 0) begin m_pc = EXC; m_mis = 1; m_bad = t; end
      else                  m_pc = t;
      m_pv = 0;
      if (halt_req) m_halt = 1;
    end
  endtask

  task automatic chk_all();
    chk("pc_out", pc_out, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("pending", 32'(redirect_pending), 32'(m_pv));
    chk("halted", 32'(halted), 32'(m_halt));
    chk("misalign", 32'(misalign), 32'(m_mis));
    chk("bad_addr", bad_addr, m_bad);
  endtask

  task automatic idle();
    stall = 0; branch_taken = 0; jump = 0; eret = 0;
    exc_req = 0; halt_req = 0; resume = 0;
  endtask

  // Apply current inputs for one edge, then check at the falling edge.
  task automatic cyc();
    @(posedge clk);
    m_step();
    @(negedge clk);
    chk_all();
  endtask

  // Assert reset in the middle of a cycle and release at a falling edge.
  task automatic async_rst();
    #2 rst = 1'b0;
    #1 m_reset();
    chk_all();
    @(posedge clk);
    @(negedge clk);
    chk_all();
    rst = 1'b1;
  endtask

  initial begin
    m_reset();
    idle();
    #12;
    chk_all();
    @(negedge clk);
    rst = 1'b1;

    // sequential run from reset
    cyc(); chk("tp_seq4", pc_out, 32'h4);
    cyc(); cyc(); chk("tp_seqC", pc_out, 32'hC);

    // async reset with pc=0x40
    jump = 1; jump_target = 32'h40; cyc(); idle();
    chk("tp_pc40", pc_out, 32'h40);
    async_rst();
    chk("tp_rst", pc_out, 32'h0);

    // stalled branch is held then applied
    jump = 1; jump_target = 32'h10; cyc(); idle();
    stall = 1; branch_taken = 1; branch_target = 32'h200;
    cyc(); cyc();
    chk("tp_hold", pc_out, 32'h10);
    chk("tp_pend", 32'(redirect_pending), 32'd1);
    idle(); cyc();
    chk("tp_apply", pc_out, 32'h200);

    // priority and exception
    jump = 1; jump_target = 32'h300;
    branch_taken = 1; branch_target = 32'h400; cyc();
    chk("tp_prio", pc_out, 32'h300);
    exc_req = 1; cyc(); idle();
    chk("tp_exc", pc_out, EXC);

    // misaligned jump traps
    jump = 1; jump_target = 32'h302; cyc(); idle();
    chk("tp_mis", 32'(misalign), 32'd1);
    chk("tp_bad", bad_addr, 32'h302);
    cyc();
    chk("tp_mis_off", 32'(misalign), 32'd0);

    // halt / resume / exception out of halt
    jump = 1; jump_target = 32'h20; cyc(); idle();
    halt_req = 1; cyc(); idle();
    chk("tp_halt_pc", pc_out, 32'h24);
    branch_taken = 1; branch_target = 32'h500; cyc(); idle();
    chk("tp_halt_hold", pc_out, 32'h24);
    resume = 1; halt_req = 1; cyc(); idle();
    chk("tp_resume", 32'(halted), 32'd0);
    cyc();
    chk("tp_after", pc_out, 32'h28);
    halt_req = 1; cyc(); idle();
    exc_req = 1; cyc(); idle();
    chk("tp_halt_exc", pc_out, EXC);

    // 8-bit wrap on the narrow instance
    async_rst();
    jump = 1; jump_target = 32'hFC; cyc(); idle();
    chk("w8_pc", 32'(pc8), 32'hFC);
    chk("w8_p4", 32'(pc8_p4), 32'h00);
    cyc();
    chk("w8_wrap", 32'(pc8), 32'h00);
    chk("w8_flags", {29'd0, pend8, halt8, mis8}, 32'd0);
    chk("w8_bad", 32'(bad8), 32'd0);

    // 32-bit wrap
    jump = 1; jump_target = 32'hFFFF_FFFC; cyc(); idle();
    cyc();
    chk("w32_wrap", pc_out, 32'h0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      stall         = ($urandom_range(0, 99) < 35);
      branch_taken  = ($urandom_range(0, 99) < 25);
      jump          = ($urandom_range(0, 99) < 15);
      eret          = ($urandom_range(0, 99) < 8);
      exc_req       = ($urandom_range(0, 99) < 4);
      halt_req      = ($urandom_range(0, 99) < 5);
      resume        = ($urandom_range(0, 99) < 20);
      branch_target = $urandom & 32'hFFFF_FFFC;
      jump_target   = $urandom & 32'hFFFF_FFFC;
      epc_in        = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) branch_target[1:0] = 2'($urandom);
      if ($urandom_range(0, 9) == 0) jump_target[1:0]   = 2'($urandom);
      if ($urandom_range(0, 9) == 0) epc_in[1:0]        = 2'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        idle();
        async_rst();
      end else begin
        cyc();
      end
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
